// File: rtl/multicycle_mem_port.sv
// Memory access port: turns controller access states into a registered
// req/ready handshake with stall, IR/MDR capture and access timeout.
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject misaligned requests).
module multicycle_mem_port #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ir_write_enable,
    input  logic              data_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              err_clear,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              align_err,
`endif
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic [1:0] {
        T_FETCH,
        T_LOAD,
        T_STORE
    } acc_t;

    state_t           r_state;
    acc_t             r_type;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold;

    logic             w_any_req;
    logic             w_misalign;
    logic             w_accept;
    logic             w_reject;
    logic             w_timeout;
    acc_t             w_type;

    // Arbitrate simultaneous requests: fetch over load over store.
    always_comb begin
        w_type = T_STORE;
        if (ir_write_enable) begin
            w_type = T_FETCH;
        end else if (data_read) begin
            w_type = T_LOAD;
        end
    end

    assign w_any_req = ir_write_enable | data_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = (addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // r_hold gives the controller one stall-free cycle after an abort.
    assign w_accept  = (r_state == S_IDLE) & w_any_req & ~r_hold & ~w_misalign;
    assign w_reject  = (r_state == S_IDLE) & w_any_req & ~r_hold & w_misalign;
    assign w_timeout = (TIMEOUT > 0) & (r_state == S_BUSY) & ~mem_ready
                     & (r_cnt == TO_LAST);

    assign mem_stall = w_accept | ((r_state == S_BUSY) & ~mem_ready);

    // Access FSM with registered memory-side outputs and capture registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_type      <= T_FETCH;
            r_cnt       <= '0;
            r_hold      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr       <= '0;
            read_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_hold <= 1'b0;
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_BUSY;
                        r_type    <= w_type;
                        r_cnt     <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= (w_type == T_STORE);
                        mem_addr  <= addr & ~ADDR_W'(3);
                        mem_wdata <= wdata;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        if (r_type == T_FETCH) begin
                            instr <= mem_rdata;
                        end
                        if (r_type == T_LOAD) begin
                            read_data <= mem_rdata;
                        end
                        r_state <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end else if (w_timeout) begin
                        r_state     <= S_IDLE;
                        r_hold      <= 1'b1;
                        mem_req     <= 1'b0;
                        mem_we      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Sticky misalignment flag; a new event wins over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            align_err <= 1'b0;
        end else if (w_reject) begin
            align_err <= 1'b1;
        end else if (err_clear) begin
            align_err <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_reject;
`endif

endmodule

// File: tb/tb_multicycle_mem_port.sv
// Randomised bench for multicycle_mem_port against a transaction-level
// model: stall length, capture targets, timeout abort and reset.
module tb_multicycle_mem_port;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ir_write_enable = 1'b0;
    logic        data_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_stall;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        err_clear = 1'b0;
    logic        timeout_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        align_err;
`endif

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_instr = '0;
    logic [31:0] m_rd = '0;
    logic        m_terr = 1'b0;

    multicycle_mem_port #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ir_write_enable(ir_write_enable),
        .data_read(data_read),
        .mem_write(mem_write),
        .addr(addr),
        .wdata(wdata),
        .mem_stall(mem_stall),
        .instr(instr),
        .read_data(read_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .err_clear(err_clear),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err(align_err),
`endif
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One controller access with nw wait cycles before memory is ready.
    task automatic access(input logic f, input logic l, input logic s,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int nw);
        logic ab;
        logic ewe;
        int   busy;
        int   stalls;
        ab   = (nw >= TO);
        busy = ab ? TO : nw + 1;
        ewe  = s & ~f & ~l;
        @(negedge clk);
        ir_write_enable = f;
        data_read = l;
        mem_write = s;
        addr = a;
        wdata = wd;
        mem_ready = 1'b0;
        #1;
        stalls = int'(mem_stall);
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("instr_pre", instr, m_instr);
        chk("rdata_pre", read_data, m_rd);
        for (int k = 0; k < busy; k++) begin
            @(negedge clk);
            mem_ready = !ab && (k == nw);
            mem_rdata = mem_ready ? rd : $urandom;
            #1;
            stalls += int'(mem_stall);
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("we", 32'(mem_we), 32'(ewe));
            chk("maddr", mem_addr, a & ~32'd3);
            chk("mwdata", mem_wdata, wd);
        end
        if (ab) begin
            m_terr = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            chk("abort_release", 32'(mem_stall), 32'd0);
            chk("abort_req", 32'(mem_req), 32'd0);
        end else if (f) begin
            m_instr = rd;
        end else if (l) begin
            m_rd = rd;
        end
        @(negedge clk);
        ir_write_enable = 1'b0;
        data_read = 1'b0;
        mem_write = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk("stall_cycles", 32'(stalls), 32'(1 + (ab ? TO : nw)));
        chk("instr", instr, m_instr);
        chk("read_data", read_data, m_rd);
        chk("req_done", 32'(mem_req), 32'd0);
        chk("terr", 32'(timeout_err), 32'(m_terr));
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clear = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        err_clear = 1'b0;
        m_terr = 1'b0;
        #1;
        chk("terr_clear", 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int r;
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;

        access(1, 0, 0, 32'h10, 32'h0, 32'hE3A01005, 0);
        access(0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        access(0, 0, 1, 32'h200, 32'h12345678, 32'h0, 1);
        access(0, 1, 0, 32'h300, 32'h0, 32'hCAFEF00D, 10);
        clear_err();
`ifndef MEM_ALIGN_CHECK_EN
        access(0, 1, 0, 32'h102, 32'h0, 32'h0BADCAFE, 0);
`endif
        access(1, 0, 1, 32'h40, 32'h55AA55AA, 32'h11223344, 2);

        // Reset in the middle of a fetch.
        @(negedge clk);
        ir_write_enable = 1'b1;
        addr = 32'h80;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_req_before", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        ir_write_enable = 1'b0;
        #1;
        m_instr = '0;
        m_rd = '0;
        m_terr = 1'b0;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_instr", instr, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("rst_late_ready", instr, 32'd0);
        chk("rst_late_req", 32'(mem_req), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            r = $urandom_range(1, 7);
            ra = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
            ra[1:0] = 2'b00;
`endif
            access(1'(r & 1), 1'((r >> 1) & 1), 1'((r >> 2) & 1), ra,
                   $urandom, $urandom, $urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) begin
                clear_err();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
